fpu_req_driver: RTL

Request-side front end for the `fpu` datapath. It accepts floating-point operation requests over a valid/ready handshake, drives `A`/`B`/`opcode` into the fixed-latency `fpu`, and captures `outp` after `LATENCY` cycles. Captured results are returned in order over a valid/ready response channel. Credit-based issue throttling guarantees that no result is ever lost under response back-pressure.

---
 rtl/fpu_pkg.sv | 18 +
 rtl/fpu_rsp_fifo.sv | 63 ++++++
 rtl/fpu_req_driver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu request front end: operand width, opcodes
// and the registered request bundle driven into the fpu.
package fpu_pkg;

   localparam int unsigned FP_W = 32;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef struct packed {
      logic [FP_W-1:0] a;
      logic [FP_W-1:0] b;
      logic [1:0]      op;
   } fpu_req_t;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Show-ahead synchronous FIFO for fpu results. The head entry is always
// visible on head_data; pointers carry one extra wrap bit so full/empty are
// told apart by the MSBs.
module fpu_rsp_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             full;
   logic             do_pop;

   // Flag decode from the pointer pair
   always_comb begin
      empty  = (wr_q == rd_q);
      full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      do_pop = pop && !empty;
      count  = wr_q - rd_q;
   end

   assign head_data = mem_q[rd_q[AW-1:0]];

   // Storage and pointer update; memory is cleared so nothing stale survives reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
            wr_q                <= wr_q + PTR_ONE;
         end
         if (do_pop) begin
            rd_q <= rd_q + PTR_ONE;
         end
      end
   end

   // Issue credits must make overflow impossible
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         assert (!full);
      end
   end

endmodule

// File: rtl/fpu_req_driver.sv
// Request-side front end for the fixed-latency fpu. Registers accepted
// operands into the fpu, tracks in-flight ops in a LATENCY-bit shift register,
// captures results into a show-ahead FIFO, and throttles issue with credits so
// back-pressure can never drop a result.
// Optional build macro: FPU_REQ_TAG_EN carries a request tag through to rsp_tag.
module fpu_req_driver
   import fpu_pkg::*;
#(
   parameter int unsigned LATENCY = 5,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TAG_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [FP_W-1:0]   req_a,
   input  logic [FP_W-1:0]   req_b,
   input  logic [1:0]        req_op,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [FP_W-1:0]   rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [FP_W-1:0]   fpu_a,
   output logic [FP_W-1:0]   fpu_b,
   output logic [1:0]        fpu_opcode,
   input  logic [FP_W-1:0]   fpu_outp,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   // Wide enough for DEPTH and LATENCY up to 16 each
   localparam int unsigned CR_W  = 6;

`ifdef FPU_REQ_TAG_EN
   localparam int unsigned FW = FP_W + TAG_W;
`else
   localparam int unsigned FW = FP_W;
`endif

   fpu_req_t          req_q;
   logic [LATENCY-1:0] pend_q;
   logic [LATENCY-1:0] pend_d;
   logic [CR_W-1:0]   pend_cnt;
   logic [CR_W-1:0]   credit;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              accept;
   logic              push;
   logic              pop;
   logic [FW-1:0]     push_data;
   logic [FW-1:0]     head_data;

   // Credits come only from registered state, so a pop frees its slot a cycle later
   always_comb begin
      pend_cnt = '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
         pend_cnt = pend_cnt + CR_W'(pend_q[i]);
      end
      credit    = CR_W'(DEPTH) - CR_W'(fifo_count) - pend_cnt;
      req_ready = (credit != '0);
      accept    = req_valid && req_ready;
      pend_d    = pend_q << 1;
      pend_d[0] = accept;
      push      = pend_q[LATENCY-1];
      pop       = rsp_valid && rsp_ready;
   end

   // Operand registers and in-flight tracker
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q  <= '0;
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
         if (accept) begin
            req_q <= '{a: req_a, b: req_b, op: req_op};
         end
      end
   end

   assign fpu_a      = req_q.a;
   assign fpu_b      = req_q.b;
   assign fpu_opcode = req_q.op;

`ifdef FPU_REQ_TAG_EN
   logic [TAG_W-1:0] tag_q [LATENCY];

   // Tag pipe runs in lockstep with pend so the tag meets its result at push
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= req_tag;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign push_data = {tag_q[LATENCY-1], fpu_outp};
   assign rsp_data  = head_data[FP_W-1:0];
   assign rsp_tag   = head_data[FP_W +: TAG_W];
`else
   logic unused_req_tag;

   assign unused_req_tag = ^req_tag;
   assign push_data      = fpu_outp;
   assign rsp_data       = head_data;
   assign rsp_tag        = '0;
`endif

   fpu_rsp_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head_data (head_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign rsp_valid = !fifo_empty;
   assign busy      = (|pend_q) || !fifo_empty;

endmodule
